cache_mem_responder: RTL and testbench

- Memory-side end of the cache line-transfer interface.
- Accepts one line-granular request at a time, either a line fill (read) or a write-back (write).
- Streams LINE_SIZE 32-bit words per burst, one beat per cycle, after a programmable access latency.
- Holds a word-addressed backing array. Sits between the cache controller and the board memory model; it is also used as the memory model in cache benches.

---
 rtl/cache_mem_pkg.sv | 28 ++
 rtl/cache_mem_responder_if.sv | 32 +++
 rtl/mem_resp_beat_counter.sv | 28 ++
 rtl/cache_mem_responder.sv | 154 +++++++++++++++
 tb/tb_cache_mem_responder.sv | 288 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cache_mem_pkg.sv
// Shared types and line geometry for cache_mem_responder.
// Line size comes from `CACHE_B (byte-offset bits, defaults to 4 = 16-byte lines).
`ifndef CACHE_B
`define CACHE_B 4
`endif

package cache_mem_pkg;

    localparam int OFFSET_WIDTH  = `CACHE_B;
    localparam int BEAT_W        = OFFSET_WIDTH - 2;
    localparam int LINE_SIZE     = 2 ** BEAT_W;
    localparam int DEF_MEM_WORDS = 1024;
    localparam int LINE_COUNT    = DEF_MEM_WORDS / LINE_SIZE;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        BURST_RD,
        BURST_WR
    } state_t;

    typedef logic [BEAT_W-1:0] beat_t;

    function automatic int line_count(input int mem_words);
        return mem_words / LINE_SIZE;
    endfunction

endpackage

// File: rtl/cache_mem_responder_if.sv
// Line-transfer bus between a cache controller (master) and the memory responder (slave).
interface cache_mem_responder_if;
    import cache_mem_pkg::*;

    logic        req_i;
    logic        req_ready_o;
    logic        we_i;
    logic [31:0] addr_i;
    logic        wvalid_i;
    logic [31:0] wdata_i;
    logic        wready_o;
    logic        rvalid_o;
    logic [31:0] rdata_o;
    beat_t       beat_o;
    logic        rlast_o;
    logic        done_o;
    logic [31:0] rd_count_o;
    logic [31:0] wr_count_o;

    modport master (
        output req_i, we_i, addr_i, wvalid_i, wdata_i,
        input  req_ready_o, wready_o, rvalid_o, rdata_o, beat_o, rlast_o, done_o,
               rd_count_o, wr_count_o
    );

    modport slave (
        input  req_i, we_i, addr_i, wvalid_i, wdata_i,
        output req_ready_o, wready_o, rvalid_o, rdata_o, beat_o, rlast_o, done_o,
               rd_count_o, wr_count_o
    );

endinterface

// File: rtl/mem_resp_beat_counter.sv
// Clear/enable counter wrapping at MOD, with a flag for the final count.
// Shared by the access-latency wait and the per-line beat index.
module mem_resp_beat_counter #(
    parameter int MOD = 4,
    parameter int W   = (MOD > 1) ? $clog2(MOD) : 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] cnt_o,
    output logic         last_o
);

    logic [W-1:0] cnt_q;

    assign last_o = (cnt_q == W'(MOD - 1));
    assign cnt_o  = cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i || clr_i) begin
            cnt_q <= '0;
        end else if (en_i) begin
            cnt_q <= last_o ? '0 : cnt_q + W'(1);
        end
    end

endmodule

// File: rtl/cache_mem_responder.sv
// Memory-side line-transfer responder: one fill or write-back burst at a time, word-addressed array.
// Optional CACHE_MEM_STATS_EN adds saturating completed-fill / completed-write-back counters.
module cache_mem_responder
    import cache_mem_pkg::*;
#(
    parameter int LATENCY   = 2,
    parameter int MEM_WORDS = DEF_MEM_WORDS
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    cache_mem_responder_if.slave  bus
);

    localparam int LINES   = line_count(MEM_WORDS);
    localparam int LINE_W  = (LINES > 1) ? $clog2(LINES) : 1;
    localparam int LAT_MOD = (LATENCY > 0) ? LATENCY : 1;
    localparam int LAT_W   = (LAT_MOD > 1) ? $clog2(LAT_MOD) : 1;

    state_t state_q, state_d;
    logic [LINE_W-1:0] line_q, line_in;
    logic              we_q;
    logic              done_q, done_d;
    logic              accept;

    logic              lat_clr, lat_en, lat_last;
    logic [LAT_W-1:0]  lat_cnt_unused;
    logic              beat_clr, beat_en, beat_last;
    beat_t             beat;

    logic              mem_we;
    logic [LINE_W+BEAT_W-1:0] idx;
    logic [31:0]       mem [MEM_WORDS];

    // Upper address bits beyond the array simply wrap onto it.
    assign line_in = LINE_W'((bus.addr_i >> OFFSET_WIDTH) % LINES);
    assign accept  = (state_q == IDLE) && bus.req_i;
    assign idx     = {line_q, beat};

    mem_resp_beat_counter #(.MOD(LAT_MOD)) u_lat_cnt (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  (lat_clr),
        .en_i   (lat_en),
        .cnt_o  (lat_cnt_unused),
        .last_o (lat_last)
    );

    mem_resp_beat_counter #(.MOD(LINE_SIZE), .W(BEAT_W)) u_beat_cnt (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr_i  (beat_clr),
        .en_i   (beat_en),
        .cnt_o  (beat),
        .last_o (beat_last)
    );

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
            line_q  <= '0;
            we_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            done_q  <= done_d;
            if (accept) begin
                line_q <= line_in;
                we_q   <= bus.we_i;
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        done_d   = 1'b0;
        lat_clr  = 1'b0;
        lat_en   = 1'b0;
        beat_clr = 1'b0;
        beat_en  = 1'b0;
        mem_we   = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.req_i) begin
                    lat_clr  = 1'b1;
                    beat_clr = 1'b1;
                    if (LATENCY > 0) state_d = WAIT;
                    else             state_d = bus.we_i ? BURST_WR : BURST_RD;
                end
            end
            WAIT: begin
                lat_en = 1'b1;
                if (lat_last) begin
                    beat_clr = 1'b1;
                    state_d  = we_q ? BURST_WR : BURST_RD;
                end
            end
            BURST_RD: begin
                beat_en = 1'b1;
                if (beat_last) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            BURST_WR: begin
                if (bus.wvalid_i) begin
                    mem_we  = 1'b1;
                    beat_en = 1'b1;
                    if (beat_last) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Array is deliberately not reset; a beat presented while reset is high is dropped.
    always_ff @(posedge clk_i) begin
        if (mem_we && !rst_i) mem[idx] <= bus.wdata_i;
    end

    assign bus.req_ready_o = (state_q == IDLE);
    assign bus.rvalid_o    = (state_q == BURST_RD);
    assign bus.wready_o    = (state_q == BURST_WR);
    assign bus.rdata_o     = bus.rvalid_o ? mem[idx] : 32'd0;
    assign bus.rlast_o     = bus.rvalid_o && beat_last;
    assign bus.beat_o      = (bus.rvalid_o || bus.wready_o) ? beat : '0;
    assign bus.done_o      = done_q;

`ifdef CACHE_MEM_STATS_EN
    logic [31:0] rd_cnt_q, wr_cnt_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_cnt_q <= 32'd0;
            wr_cnt_q <= 32'd0;
        end else if (done_d) begin
            if (we_q) begin
                if (wr_cnt_q != 32'hFFFF_FFFF) wr_cnt_q <= wr_cnt_q + 32'd1;
            end else begin
                if (rd_cnt_q != 32'hFFFF_FFFF) rd_cnt_q <= rd_cnt_q + 32'd1;
            end
        end
    end

    assign bus.rd_count_o = rd_cnt_q;
    assign bus.wr_count_o = wr_cnt_q;
`else
    assign bus.rd_count_o = 32'd0;
    assign bus.wr_count_o = 32'd0;
`endif

endmodule

// File: tb/tb_cache_mem_responder.sv
// Randomized scoreboard bench for cache_mem_responder against an array-based reference model.
module tb_cache_mem_responder;
    import cache_mem_pkg::*;

    localparam int LAT   = 2;
    localparam int MW    = 1024;
    localparam int LINES = MW / LINE_SIZE;

    typedef struct {
        logic [31:0] data;
        int          beat;
        bit          last;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cache_mem_responder_if bus();

    cache_mem_responder #(.LATENCY(LAT), .MEM_WORDS(MW)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] model [MW];
    bit          written [LINES];
    int          wl [$];
    exp_t        rd_q [$];
    int          rd_done = 0, wr_done = 0;
    int          done_exp = 0, done_seen = 0;
    int          tb_wbeat = -1;
    bit          just_done = 0;
    bit          mon_en = 0;
    bit          last_prev = 0;
    logic [31:0] dat [LINE_SIZE];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_vec++;
        n_err++;
        $display("FAIL %s: bound expired", name);
    endtask

    function automatic int line_of(input logic [31:0] addr);
        return int'((addr >> OFFSET_WIDTH) % LINES);
    endfunction

    // Monitor: pops expected read beats, checks done timing and idle outputs.
    always @(negedge clk) begin
        exp_t e;
        bit   rd_last;
        if (mon_en) begin
            if (bus.done_o || last_prev) check("done_timing", 32'(bus.done_o), 32'(last_prev));
            if (bus.done_o) done_seen++;
            rd_last = 1'b0;
            if (bus.rvalid_o) begin
                if (rd_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL rvalid_unexpected: got rvalid=1 want 0");
                end else begin
                    e = rd_q.pop_front();
                    check("rdata", bus.rdata_o, e.data);
                    check("rbeat", 32'(bus.beat_o), e.beat);
                    check("rlast", 32'(bus.rlast_o), 32'(e.last));
                    rd_last = e.last;
                end
            end
            if (bus.req_ready_o) begin
                check("idle_flags", {29'd0, bus.rvalid_o, bus.wready_o, bus.rlast_o}, 32'd0);
                check("idle_rdata", bus.rdata_o, 32'd0);
                check("idle_beat", 32'(bus.beat_o), 32'd0);
            end
            last_prev = !rst && (rd_last ||
                        (bus.wready_o && bus.wvalid_i && tb_wbeat == LINE_SIZE - 1));
        end
    end

    // Called at posedge+1 of an IDLE cycle; returns at posedge+1 of the first cycle after acceptance.
    task automatic accept(input bit we, input logic [31:0] addr, output bit ok);
        bus.req_i  = 1'b1;
        bus.we_i   = we;
        bus.addr_i = addr;
        @(negedge clk);
        ok = bus.req_ready_o;
        check("accept_ready", 32'(bus.req_ready_o), 32'd1);
        check("done_at_accept", 32'(bus.done_o), 32'(just_done));
        just_done = 1'b0;
        @(posedge clk); #1;
        bus.req_i  = 1'b0;
        bus.we_i   = 1'($urandom);
        bus.addr_i = $urandom;
    endtask

    task automatic do_read(input logic [31:0] addr);
        int line = line_of(addr);
        int lat  = 1;
        int n    = 0;
        bit ok;
        for (int k = 0; k < LINE_SIZE; k++)
            rd_q.push_back('{model[line*LINE_SIZE+k], k, k == LINE_SIZE - 1});
        accept(1'b0, addr, ok);
        if (!ok) return;
        @(negedge clk);
        while (!bus.rvalid_o && lat < 50) begin
            @(negedge clk);
            lat++;
        end
        check("rd_latency", lat, LAT + 1);
        while (!(bus.rvalid_o && bus.rlast_o) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) timeout("rd_rlast");
        else         check("rd_burst_len", n, LINE_SIZE - 1);
        @(posedge clk); #1;
        rd_done++;
        done_exp++;
        just_done = 1'b1;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [31:0] d [LINE_SIZE],
                            input int stall_after, input int stall_len, input int abort_at);
        int line = line_of(addr);
        bit ok;
        accept(1'b1, addr, ok);
        if (!ok) return;
        for (int k = 0; k < LINE_SIZE; k++) begin
            int n = 0;
            bus.wvalid_i = 1'b1;
            bus.wdata_i  = d[k];
            tb_wbeat     = k;
            @(negedge clk);
            while (!bus.wready_o && n < 50) begin
                @(negedge clk);
                n++;
            end
            if (!bus.wready_o) begin
                timeout("wready");
                bus.wvalid_i = 1'b0;
                tb_wbeat = -1;
                return;
            end
            if (k == 0) check("wr_latency", n + 1, LAT + 1);
            check("wr_beat", 32'(bus.beat_o), k);
            if (k == abort_at) begin
                rst = 1'b1;
                @(posedge clk); #1;
                rst = 1'b0;
                bus.wvalid_i = 1'b0;
                tb_wbeat = -1;
                @(negedge clk);
                check("abort_idle", 32'(bus.req_ready_o), 32'd1);
                check("abort_no_done", 32'(bus.done_o), 32'd0);
                @(posedge clk); #1;
                rd_done = 0;
                wr_done = 0;
                return;
            end
            @(posedge clk); #1;
            model[line*LINE_SIZE+k] = d[k];
            if (k == stall_after && k < LINE_SIZE - 1) begin
                bus.wvalid_i = 1'b0;
                repeat (stall_len) begin
                    @(negedge clk);
                    check("stall_wready", 32'(bus.wready_o), 32'd1);
                    check("stall_beat", 32'(bus.beat_o), k + 1);
                    @(posedge clk); #1;
                end
            end
        end
        bus.wvalid_i = 1'b0;
        tb_wbeat = -1;
        if (!written[line]) begin
            written[line] = 1'b1;
            wl.push_back(line);
        end
        wr_done++;
        done_exp++;
        just_done = 1'b1;
    endtask

    task automatic fill_rand();
        for (int k = 0; k < LINE_SIZE; k++) dat[k] = $urandom;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        n_err++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1);
    end

    initial begin
        bus.req_i    = 1'b0;
        bus.we_i     = 1'b0;
        bus.addr_i   = 32'd0;
        bus.wvalid_i = 1'b0;
        bus.wdata_i  = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 32'(bus.req_ready_o), 32'd1);
        check("rst_flags", {27'd0, bus.rvalid_o, bus.wready_o, bus.rlast_o, bus.done_o, 1'b0}, 32'd0);
        check("rst_rdata", bus.rdata_o, 32'd0);
        check("rst_beat", 32'(bus.beat_o), 32'd0);
        check("rst_rd_count", bus.rd_count_o, 32'd0);
        check("rst_wr_count", bus.wr_count_o, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        mon_en = 1'b1;

        // Line 3 preload and fill
        for (int k = 0; k < LINE_SIZE; k++) dat[k] = 32'h30 + k;
        do_write(32'h0000_0030, dat, LINE_SIZE, 0, LINE_SIZE);
        do_read(32'h0000_0030);

        // Write-back with a two-cycle stall after beat 1, then readback
        fill_rand();
        do_write(32'h0000_0040, dat, 1, 2, LINE_SIZE);
        do_read(32'h0000_0040);

        // Back-to-back mixes
        fill_rand();
        do_write(32'h0000_0050, dat, LINE_SIZE, 0, LINE_SIZE);
        do_read(32'h0000_0050);
        do_read(32'h0000_0030);

        // Top-of-address-space wraps onto the last line
        fill_rand();
        do_write(32'hFFFF_FFF0, dat, LINE_SIZE, 0, LINE_SIZE);
        do_read(32'h0000_0FF0);
        do_read(32'hFFFF_FFF0);

        // Reset during beat 2 of a write-back
        for (int k = 0; k < LINE_SIZE; k++) dat[k] = 32'hA000_0000 + k;
        do_write(32'h0000_0060, dat, LINE_SIZE, 0, LINE_SIZE);
        for (int k = 0; k < LINE_SIZE; k++) dat[k] = 32'hB000_0000 + k;
        do_write(32'h0000_0060, dat, LINE_SIZE, 0, 2);
        check("abort_rd_count", bus.rd_count_o, 32'd0);
        check("abort_wr_count", bus.wr_count_o, 32'd0);
        do_read(32'h0000_0060);

        // Randomized traffic
        for (int i = 0; i < 40; i++) begin
            if (wl.size() == 0 || $urandom_range(0, 1) == 0) begin
                fill_rand();
                do_write($urandom, dat, $urandom_range(0, LINE_SIZE - 1), $urandom_range(0, 3), LINE_SIZE);
            end else begin
                logic [31:0] a;
                int          ln = wl[$urandom_range(0, wl.size() - 1)];
                a = (($urandom * LINES + ln) << OFFSET_WIDTH) | ($urandom % (1 << OFFSET_WIDTH));
                do_read(a);
            end
            if ($urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
                just_done = 1'b0;
            end
        end

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("done_count", done_seen, done_exp);
        check("rd_q_empty", rd_q.size(), 0);
`ifdef CACHE_MEM_STATS_EN
        check("rd_count", bus.rd_count_o, rd_done);
        check("wr_count", bus.wr_count_o, wr_done);
`else
        check("rd_count_off", bus.rd_count_o, 32'd0);
        check("wr_count_off", bus.wr_count_o, 32'd0);
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
